bound_flasher_ctrl: RTL and testbench

Parametrised successor to the bound-flasher next-state logic. It merges the state register, the lamp-level counter, flick edge capture and the thermometer LED decode into one clocked block. LED count and the two intermediate bounds are generic, and stepping is gated by an external rate tick. It sits between the flick-input debouncer and the LED pads.

---
 rtl/bound_flasher_pkg.sv | 32 +++
 rtl/bf_next_state_logic.sv | 163 ++++++++++++++++
 rtl/bound_flasher_ctrl.sv | 130 +++++++++++++
 tb/tb_bound_flasher_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bound_flasher_pkg.sv
// -----------------------------------------------------------------------------
// bound_flasher_pkg
// Shared types and helpers for the bound-flasher controller.
//   bf_state_t : 3-bit state encoding, also driven out on state_o
//   BF_MAX_LED : widest lamp bar the thermometer helper can decode
//   therm()    : level -> thermometer code (bit i set when i < lvl)
// -----------------------------------------------------------------------------
package bound_flasher_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP_TOP  = 3'd1,
        DN_LOW  = 3'd2,
        UP_MID  = 3'd3,
        DN_ZERO = 3'd4,
        UP_LOW  = 3'd5,
        DN_END  = 3'd6
    } bf_state_t;

    localparam int unsigned BF_MAX_LED = 32'd256;

    // Thermometer decode; callers truncate to their own lamp count.
    function automatic logic [BF_MAX_LED-1:0] therm(input logic [31:0] lvl);
        logic [BF_MAX_LED-1:0] t;
        t = {BF_MAX_LED{1'b0}};
        for (int unsigned i = 0; i < BF_MAX_LED; i++) begin
            t[i[7:0]] = (i < lvl);
        end
        return t;
    endfunction

endpackage

// File: rtl/bf_next_state_logic.sv
// -----------------------------------------------------------------------------
// bf_next_state_logic
// Purely combinational step logic of the bound flasher.
//   state, lvl   : current registered state and lamp level
//   tick         : step strobe (already qualified by any pause)
//   req_eff      : pending flick request or a flick edge this cycle
//   nxt_state    : state to load on the next clock
//   nxt_lvl      : level to load on the next clock (saturated to 0..N_LED)
//   consume_req  : clear the sticky flick request on this clock
//   done         : the current step returns the block to IDLE
// -----------------------------------------------------------------------------
module bf_next_state_logic
    import bound_flasher_pkg::*;
#(
    parameter  int N_LED = 16,
    parameter  int B_LOW = 5,
    parameter  int B_MID = 10,
    localparam int LW    = $clog2(N_LED + 1)
) (
    input  bf_state_t       state,
    input  logic [LW-1:0]   lvl,
    input  logic            tick,
    input  logic            req_eff,
    output bf_state_t       nxt_state,
    output logic [LW-1:0]   nxt_lvl,
    output logic            consume_req,
    output logic            done
);

    localparam logic [LW-1:0] ZERO_L = {LW{1'b0}};
    localparam logic [LW-1:0] ONE_L  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] TOP_L  = LW'(N_LED);
    localparam logic [LW-1:0] LOW_L  = LW'(B_LOW);
    localparam logic [LW-1:0] MID_L  = LW'(B_MID);

    logic [LW-1:0] inc_s;
    logic [LW-1:0] dec_s;

    // Saturating one-step neighbours of the current level.
    always_comb begin
        inc_s = lvl;
        dec_s = lvl;
        if (lvl >= TOP_L) begin
            inc_s = TOP_L;
        end else begin
            inc_s = lvl + ONE_L;
        end
        if (lvl == ZERO_L) begin
            dec_s = ZERO_L;
        end else begin
            dec_s = lvl - ONE_L;
        end
    end

    // State walk; every decision is taken against the level being entered.
    always_comb begin
        nxt_state   = state;
        nxt_lvl     = lvl;
        consume_req = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                nxt_lvl = ZERO_L;
                if (tick && req_eff) begin
                    nxt_state   = UP_TOP;
                    nxt_lvl     = ONE_L;
                    consume_req = 1'b1;
                end else begin
                    nxt_state = IDLE;
                end
            end
            UP_TOP: begin
                if (tick) begin
                    nxt_lvl = inc_s;
                    if (inc_s == TOP_L) begin
                        nxt_state = DN_LOW;
                    end else begin
                        nxt_state = UP_TOP;
                    end
                end else begin
                    nxt_lvl = lvl;
                end
            end
            DN_LOW: begin
                if (tick) begin
                    nxt_lvl = dec_s;
                    if (dec_s == LOW_L) begin
                        if (req_eff) begin
                            nxt_state   = UP_TOP;
                            consume_req = 1'b1;
                        end else begin
                            nxt_state = UP_MID;
                        end
                    end else begin
                        nxt_state = DN_LOW;
                    end
                end else begin
                    nxt_lvl = lvl;
                end
            end
            UP_MID: begin
                if (tick) begin
                    nxt_lvl = inc_s;
                    if (inc_s == MID_L) begin
                        nxt_state = DN_ZERO;
                    end else begin
                        nxt_state = UP_MID;
                    end
                end else begin
                    nxt_lvl = lvl;
                end
            end
            DN_ZERO: begin
                if (tick) begin
                    nxt_lvl = dec_s;
                    if (((dec_s == LOW_L) || (dec_s == ZERO_L)) && req_eff) begin
                        nxt_state   = UP_MID;
                        consume_req = 1'b1;
                    end else if (dec_s == ZERO_L) begin
                        // A request can't survive into the final low bounce.
                        nxt_state   = UP_LOW;
                        consume_req = 1'b1;
                    end else begin
                        nxt_state = DN_ZERO;
                    end
                end else begin
                    nxt_lvl = lvl;
                end
            end
            UP_LOW: begin
                if (tick) begin
                    nxt_lvl = inc_s;
                    if (inc_s == LOW_L) begin
                        nxt_state = DN_END;
                    end else begin
                        nxt_state = UP_LOW;
                    end
                end else begin
                    nxt_lvl = lvl;
                end
            end
            DN_END: begin
                if (tick) begin
                    nxt_lvl = dec_s;
                    if (dec_s == ZERO_L) begin
                        nxt_state = IDLE;
                        done      = 1'b1;
                    end else begin
                        nxt_state = DN_END;
                    end
                end else begin
                    nxt_lvl = lvl;
                end
            end
            default: begin
                // Corrupted encoding: recover immediately, tick or not.
                nxt_state = IDLE;
                nxt_lvl   = ZERO_L;
            end
        endcase
    end

endmodule

// File: rtl/bound_flasher_ctrl.sv
// -----------------------------------------------------------------------------
// bound_flasher_ctrl
// Bound-flasher controller: state register, lamp level, flick edge capture and
// thermometer LED decode in one clocked block. Sits between the flick
// debouncer and the LED pads.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   tick_i   : step strobe; state and level only move on tick cycles
//   flk_i    : flick level, already synchronised to clk
//   pause_i  : (BOUND_FLASHER_PAUSE_EN only) freezes stepping, flicks still latch
//   leds_o   : thermometer lamp bar, bit i lit when i < level
//   lvl_o    : current lamp level, 0..N_LED
//   state_o  : current state (bf_state_t encoding)
//   busy_o   : high whenever the block is not IDLE
//   done_o   : one-cycle pulse after the step that returns to IDLE
// Optional feature macro: BOUND_FLASHER_PAUSE_EN (adds pause_i).
// -----------------------------------------------------------------------------
module bound_flasher_ctrl
    import bound_flasher_pkg::*;
#(
    parameter  int N_LED = 16,
    parameter  int B_LOW = 5,
    parameter  int B_MID = 10,
    localparam int LW    = $clog2(N_LED + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             flk_i,
`ifdef BOUND_FLASHER_PAUSE_EN
    input  logic             pause_i,
`endif
    output logic [N_LED-1:0] leds_o,
    output logic [LW-1:0]    lvl_o,
    output logic [2:0]       state_o,
    output logic             busy_o,
    output logic             done_o
);

    if (!((B_LOW > 0) && (B_LOW < B_MID) && (B_MID < N_LED) && (N_LED <= BF_MAX_LED)))
    begin : g_bound_order_err
        $error("bound_flasher_ctrl: need 0 < B_LOW < B_MID < N_LED <= 256");
    end

    bf_state_t         state_r;
    bf_state_t         nxt_state_s;
    logic [LW-1:0]     lvl_r;
    logic [LW-1:0]     nxt_lvl_s;
    logic              flk_q_r;
    logic              flk_req_r;
    logic              edge_s;
    logic              req_eff_s;
    logic              capture_s;
    logic              consume_s;
    logic              done_s;
    logic              tick_eff_s;
    logic [N_LED-1:0]  leds_r;
    logic              done_r;
    logic              busy_r;

`ifdef BOUND_FLASHER_PAUSE_EN
    assign tick_eff_s = tick_i & ~pause_i;
`else
    assign tick_eff_s = tick_i;
`endif

    assign edge_s    = flk_i & ~flk_q_r;
    // An edge arriving on the deciding tick counts as a request.
    assign req_eff_s = flk_req_r | edge_s;

    // Flick edges only latch in the states that can act on them later.
    always_comb begin
        capture_s = 1'b0;
        case (state_r)
            IDLE, DN_LOW, DN_ZERO: capture_s = edge_s;
            default:               capture_s = 1'b0;
        endcase
    end

    bf_next_state_logic #(
        .N_LED (N_LED),
        .B_LOW (B_LOW),
        .B_MID (B_MID)
    ) u_nsl (
        .state       (state_r),
        .lvl         (lvl_r),
        .tick        (tick_eff_s),
        .req_eff     (req_eff_s),
        .nxt_state   (nxt_state_s),
        .nxt_lvl     (nxt_lvl_s),
        .consume_req (consume_s),
        .done        (done_s)
    );

    // State, level, flick tracking and registered output images.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            lvl_r     <= {LW{1'b0}};
            flk_q_r   <= 1'b0;
            flk_req_r <= 1'b0;
            leds_r    <= {N_LED{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            lvl_r   <= nxt_lvl_s;
            flk_q_r <= flk_i;
            // Consumption wins over a same-cycle capture.
            if (consume_s) begin
                flk_req_r <= 1'b0;
            end else if (capture_s) begin
                flk_req_r <= 1'b1;
            end else begin
                flk_req_r <= flk_req_r;
            end
            // Decoded from the level being loaded so leds_o always matches lvl_o.
            leds_r <= N_LED'(therm(32'(nxt_lvl_s)));
            done_r <= done_s;
            busy_r <= (nxt_state_s != IDLE);
        end
    end

    assign leds_o  = leds_r;
    assign lvl_o   = lvl_r;
    assign state_o = state_r;
    assign busy_o  = busy_r;
    assign done_o  = done_r;

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Self-checking bench: two instances (16/5/10 and 8/2/5) share the stimulus;
// a behavioural model pushes expectations into a scoreboard that is drained
// after each clock edge.
module tb_bound_flasher_ctrl;

    localparam int S_IDLE = 0, S_UP_TOP = 1, S_DN_LOW = 2, S_UP_MID = 3;
    localparam int S_DN_ZERO = 4, S_UP_LOW = 5, S_DN_END = 6;

    typedef struct {
        int inst;
        int st;
        int lvl;
        int leds;
        int done;
        int busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic flk = 1'b0;
    logic pause = 1'b0;

    logic [15:0] leds1;
    logic [4:0]  lvl1;
    logic [2:0]  st1;
    logic        busy1, done1;
    logic [7:0]  leds2;
    logic [3:0]  lvl2;
    logic [2:0]  st2;
    logic        busy2, done2;

    int checks = 0;
    int failures = 0;

    int n_led[2] = '{16, 8};
    int b_low[2] = '{5, 2};
    int b_mid[2] = '{10, 5};
    int m_state[2];
    int m_lvl[2];
    int m_req[2];
    int m_flkq[2];
    int m_done[2];

    exp_t sb[$];

    always #5 clk = ~clk;

    bound_flasher_ctrl u_dut16 (
        .clk(clk), .rst_n(rst_n), .tick_i(tick), .flk_i(flk),
`ifdef BOUND_FLASHER_PAUSE_EN
        .pause_i(pause),
`endif
        .leds_o(leds1), .lvl_o(lvl1), .state_o(st1), .busy_o(busy1), .done_o(done1)
    );

    bound_flasher_ctrl #(.N_LED(8), .B_LOW(2), .B_MID(5)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .tick_i(tick), .flk_i(flk),
`ifdef BOUND_FLASHER_PAUSE_EN
        .pause_i(pause),
`endif
        .leds_o(leds2), .lvl_o(lvl2), .state_o(st2), .busy_o(busy2), .done_o(done2)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = S_IDLE; m_lvl[d] = 0; m_req[d] = 0; m_flkq[d] = 0; m_done[d] = 0;
        end
    endtask

    // Reference behaviour written straight from the state walk description.
    task automatic model_step(input int d, input bit tk, input bit fk);
        bit eg, reff, cap;
        eg   = fk && (m_flkq[d] == 0);
        reff = (m_req[d] != 0) || eg;
        cap  = eg && (m_state[d] == S_IDLE || m_state[d] == S_DN_LOW || m_state[d] == S_DN_ZERO);
        m_done[d] = 0;
        if (tk) begin
            case (m_state[d])
                S_IDLE: if (reff) begin m_state[d] = S_UP_TOP; m_lvl[d] = 1; m_req[d] = 0; cap = 0; end
                S_UP_TOP: begin
                    m_lvl[d]++;
                    if (m_lvl[d] == n_led[d]) m_state[d] = S_DN_LOW;
                end
                S_DN_LOW: begin
                    m_lvl[d]--;
                    if (m_lvl[d] == b_low[d]) begin
                        if (reff) begin m_state[d] = S_UP_TOP; m_req[d] = 0; cap = 0; end
                        else m_state[d] = S_UP_MID;
                    end
                end
                S_UP_MID: begin
                    m_lvl[d]++;
                    if (m_lvl[d] == b_mid[d]) m_state[d] = S_DN_ZERO;
                end
                S_DN_ZERO: begin
                    m_lvl[d]--;
                    if ((m_lvl[d] == b_low[d] || m_lvl[d] == 0) && reff) begin
                        m_state[d] = S_UP_MID; m_req[d] = 0; cap = 0;
                    end else if (m_lvl[d] == 0) begin
                        m_state[d] = S_UP_LOW; m_req[d] = 0; cap = 0;
                    end
                end
                S_UP_LOW: begin
                    m_lvl[d]++;
                    if (m_lvl[d] == b_low[d]) m_state[d] = S_DN_END;
                end
                S_DN_END: begin
                    m_lvl[d]--;
                    if (m_lvl[d] == 0) begin m_state[d] = S_IDLE; m_done[d] = 1; end
                end
                default: ;
            endcase
        end
        if (cap) m_req[d] = 1;
        m_flkq[d] = fk ? 1 : 0;
    endtask

    // One clock: drive, push expectations, then drain the scoreboard after the edge.
    task automatic cyc(input bit tk, input bit fk);
        exp_t e;
        int ast, al, ald, ad, ab;
        @(negedge clk);
        tick = tk;
        flk  = fk;
        for (int d = 0; d < 2; d++) begin
            model_step(d, tk && !pause, fk);
            e.inst = d; e.st = m_state[d]; e.lvl = m_lvl[d];
            e.leds = (1 << m_lvl[d]) - 1; e.done = m_done[d];
            e.busy = (m_state[d] != S_IDLE) ? 1 : 0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                ast = int'(st1); al = int'(lvl1); ald = int'(leds1); ad = int'(done1); ab = int'(busy1);
            end else begin
                ast = int'(st2); al = int'(lvl2); ald = int'(leds2); ad = int'(done2); ab = int'(busy2);
            end
            chk($sformatf("i%0d_state", e.inst), ast, e.st);
            chk($sformatf("i%0d_lvl", e.inst), al, e.lvl);
            chk($sformatf("i%0d_leds", e.inst), ald, e.leds);
            chk($sformatf("i%0d_done", e.inst), ad, e.done);
            chk($sformatf("i%0d_busy", e.inst), ab, e.busy);
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_lvl16"}, int'(lvl1), 0);
        chk({tag, "_st16"}, int'(st1), S_IDLE);
        chk({tag, "_leds16"}, int'(leds1), 0);
        chk({tag, "_busy16"}, int'(busy1), 0);
        chk({tag, "_done16"}, int'(done1), 0);
        chk({tag, "_lvl8"}, int'(lvl2), 0);
        chk({tag, "_leds8"}, int'(leds2), 0);
        chk({tag, "_st8"}, int'(st2), S_IDLE);
    endtask

    // Asynchronous reset in mid-cycle, checked before any clock edge.
    task automatic rst_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        check_cleared(tag);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (m_state[0] == S_IDLE && m_state[1] == S_IDLE) break;
            cyc(1'b1, 1'b0);
        end
        chk(tag, (m_state[0] == S_IDLE && m_state[1] == S_IDLE) ? 1 : 0, 1);
    endtask

    initial begin
        int trace[$];
        int ndone, done_idx, max8, lvl_hold;
        bit saw_up_low;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full unflicked sequence on the 16-lamp instance.
        for (int v = 1; v <= 16; v++) trace.push_back(v);
        for (int v = 15; v >= 5; v--) trace.push_back(v);
        for (int v = 6; v <= 10; v++) trace.push_back(v);
        for (int v = 9; v >= 0; v--) trace.push_back(v);
        for (int v = 1; v <= 5; v++) trace.push_back(v);
        for (int v = 4; v >= 0; v--) trace.push_back(v);
        ndone = 0; done_idx = -1; max8 = 0;
        for (int k = 0; k < trace.size(); k++) begin
            cyc(1'b1, k == 0);
            chk("t1_trace", int'(lvl1), trace[k]);
            if (done1) begin ndone++; done_idx = k; end
            if (int'(lvl2) > max8) max8 = int'(lvl2);
            if (m_lvl[1] == 4) chk("t1_leds8_lvl4", int'(leds2), 32'h0F);
        end
        chk("t1_done_count", ndone, 1);
        chk("t1_done_at_end", done_idx, trace.size() - 1);
        chk("t1_end_idle", int'(st1), S_IDLE);
        chk("t1_max8", max8, 8);
        run_idle("t1_idle");

        // Flick edge on the tick that lands DN_LOW on the lower bound.
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (m_state[0] == S_DN_LOW && m_lvl[0] == 6) break;
            cyc(1'b1, 1'b0);
        end
        chk("t2_reach", (m_state[0] == S_DN_LOW && m_lvl[0] == 6) ? 1 : 0, 1);
        cyc(1'b1, 1'b1);
        chk("t2_kick_state", int'(st1), S_UP_TOP);
        chk("t2_kick_lvl", int'(lvl1), 5);
        cyc(1'b1, 1'b0);
        chk("t2_next_lvl", int'(lvl1), 6);
        run_idle("t2_idle");

        // Flick held high from UP_MID onward: no edge, no kickback.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (m_state[0] == S_UP_MID) break;
            cyc(1'b1, 1'b0);
        end
        saw_up_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_state[0] == S_IDLE) break;
            cyc(1'b1, 1'b1);
            if (st1 == 3'(S_UP_LOW)) saw_up_low = 1'b1;
        end
        chk("t3_up_low_seen", int'(saw_up_low), 1);
        cyc(1'b1, 1'b0);
        run_idle("t3_idle");

        // Fresh edge in DN_ZERO at level 8 kicks back at the lower bound.
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (m_state[0] == S_DN_ZERO && m_lvl[0] == 8) break;
            cyc(1'b1, 1'b0);
        end
        chk("t4_reach8", int'(lvl1), 8);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (m_lvl[0] == 5) break;
            cyc(1'b1, 1'b0);
        end
        chk("t4_kick_state", int'(st1), S_UP_MID);
        for (int i = 0; i < 100; i++) begin
            if (m_state[0] == S_UP_LOW) break;
            cyc(1'b1, 1'b0);
        end
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        run_idle("t4_idle");
        repeat (5) cyc(1'b1, 1'b0);
        chk("t4_stay_idle", int'(st1), S_IDLE);

        // Sparse ticks, then async reset in mid-sequence at level 12.
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (m_lvl[0] == 12) break;
            cyc((i % 4) == 3, 1'b0);
        end
        chk("t5_reach12", int'(lvl1), 12);
        rst_pulse("t5_async");

        // A pending request is lost on reset.
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        rst_pulse("t5_req");
        repeat (3) cyc(1'b1, 1'b0);
        chk("t5_no_restart", int'(st1), S_IDLE);

`ifdef BOUND_FLASHER_PAUSE_EN
        cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0);
        lvl_hold = int'(lvl1);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b1, i == 4);
        chk("t6_pause_freeze", int'(lvl1), lvl_hold);
        pause = 1'b0;
        run_idle("t6_idle");
`else
        lvl_hold = 0;
        chk("t6_idle_lvl", int'(lvl1), lvl_hold);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
